// File: rtl/tile_river_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tile_river_pkg
// Purpose  : Shared constants and types for the tile_river arbiter slice.
// Revision : 1.0  initial release
// ============================================================================
package tile_river_pkg;
    localparam int DATA_W       = 16;
    localparam int VEC_LEN      = 10;
    localparam int NUM_REQ_DFLT = 2;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef logic [VEC_LEN*DATA_W-1:0]        vec_t;
    typedef logic [$clog2(NUM_REQ_DFLT)-1:0]  req_idx_t;
endpackage
`default_nettype wire

// File: rtl/tile_river_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tile_river_tag_fifo
// Purpose  : In-order FIFO of requester tags for vectors in flight in the engine.
// Revision : 1.0  initial release
// ============================================================================
module tile_river_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(tile_river_pkg::req_idx_t)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/tile_river_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tile_river_arbiter
// Purpose  : Round-robin sharing of one tile_river engine among NUM_REQ
//            requesters, with in-order result steering. Optional per-requester
//            accept counters when TILE_ARB_STATS_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tile_river_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int VEC_LEN      = tile_river_pkg::VEC_LEN,
    parameter int DATA_W       = tile_river_pkg::DATA_W,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*VEC_LEN*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_W-1:0]               rsp_out1,
    output logic [DATA_W-1:0]               rsp_out2,
    output logic                            eng_in_valid,
    input  logic                            eng_in_ready,
    output logic [VEC_LEN*DATA_W-1:0]       eng_in_data,
    input  logic                            eng_out_valid,
    output logic                            eng_out_ready,
    input  logic [DATA_W-1:0]               eng_out1,
    input  logic [DATA_W-1:0]               eng_out2,
    output logic                            err_orphan
`ifdef TILE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]           stat_cnt
`endif
);
    import tile_river_pkg::*;

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_vec_w = VEC_LEN * DATA_W;
    localparam int c_cnt_w = $clog2(MAX_INFLIGHT + 1);

    logic [c_vec_w-1:0] w_vec [NUM_REQ];
    logic [c_idx_w-1:0] r_rr_ptr;
    logic               r_lock;
    logic [c_idx_w-1:0] r_lock_idx;
    logic               r_orphan;
    logic [c_idx_w-1:0] w_grant;
    logic [c_idx_w-1:0] w_grant_nxt;
    logic [c_idx_w-1:0] w_cand;
    logic               w_found;
    logic               w_has_room;
    logic               w_push;
    logic               w_pop;
    logic [c_idx_w-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic [c_cnt_w-1:0] w_count;

    generate
        for (genvar r = 0; r < NUM_REQ; r++) begin : g_slice
            assign w_vec[r] = req_data[r*c_vec_w +: c_vec_w];
        end
    endgenerate

    // A stalled offer keeps its grant so the engine sees a stable vector.
    always_comb begin
        w_grant = r_rr_ptr;
        w_found = 1'b0;
        w_cand  = '0;
        if (r_lock) begin
            w_grant = r_lock_idx;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_cand = c_idx_w'((int'(r_rr_ptr) + k) % NUM_REQ);
                if (!w_found && req_valid[w_cand]) begin
                    w_grant = w_cand;
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_grant_nxt  = (w_grant == c_idx_w'(NUM_REQ - 1)) ? '0 : w_grant + c_idx_w'(1);
    assign w_has_room   = ~rst & ~w_full & (w_count < c_cnt_w'(MAX_INFLIGHT));
    assign eng_in_valid = req_valid[w_grant] & w_has_room;
    assign eng_in_data  = w_vec[w_grant];
    assign w_push       = eng_in_valid & eng_in_ready;

    always_comb begin
        req_ready          = '0;
        req_ready[w_grant] = eng_in_ready & w_has_room;
        rsp_valid          = '0;
        if (!w_empty) begin
            rsp_valid[w_head] = eng_out_valid;
        end
    end

    assign eng_out_ready = ~w_empty & rsp_ready[w_head];
    assign w_pop         = eng_out_valid & eng_out_ready;
    assign rsp_out1      = eng_out1;
    assign rsp_out2      = eng_out2;
    assign err_orphan    = r_orphan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_orphan   <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_grant_nxt;
                r_lock   <= 1'b0;
            end else if (eng_in_valid) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant;
            end
            if (eng_out_valid && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    tile_river_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (c_idx_w)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_grant),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

`ifdef TILE_ARB_STATS_EN
    generate
        for (genvar r = 0; r < NUM_REQ; r++) begin : g_stat
            logic [15:0] r_cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_push && (w_grant == c_idx_w'(r)) && (r_cnt != STAT_MAX)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign stat_cnt[r*16 +: 16] = r_cnt;
        end
    endgenerate
`endif
endmodule
`default_nettype wire

// File: doc/tile_river_arbiter.md
Name: tile_river_arbiter

Overview:
- Shares one tile_river inference engine between NUM_REQ independent requesters.
- Arbitrates input vectors onto the engine's input handshake in round-robin order.
- Records the issuing requester's index in an in-order tag FIFO.
- Steers each engine result pair (out1/out2) back to the requester that issued it.
- Sits between the requester-facing fabric and the tile_river instance, in the same clock/reset domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- VEC_LEN, 10, 16-bit elements per input vector.
- DATA_W, 16, element and output width.
- MAX_INFLIGHT, 4, maximum vectors accepted by the engine but not yet returned; also the tag FIFO depth (power of 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester vector valid.
- req_ready  out  NUM_REQ  per-requester vector accept.
- req_data  in  NUM_REQ*VEC_LEN*DATA_W  flattened vectors; requester r occupies slice r.
- rsp_valid  out  NUM_REQ  per-requester result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_out1  out  DATA_W  shared result bus 1, meaningful only where rsp_valid is set.
- rsp_out2  out  DATA_W  shared result bus 2, meaningful only where rsp_valid is set.
- eng_in_valid  out  1  to engine testinput_valid.
- eng_in_ready  in  1  from engine input ready.
- eng_in_data  out  VEC_LEN*DATA_W  to engine input vector.
- eng_out_valid  in  1  from engine output valid.
- eng_out_ready  out  1  to engine output ready.
- eng_out1  in  DATA_W  engine output 1.
- eng_out2  in  DATA_W  engine output 2.
- err_orphan  out  1  sticky: engine produced a result with no outstanding tag.

Behaviour:
- Reset (async assert, applied immediately):
  - req_ready=0, rsp_valid=0, eng_in_valid=0, eng_out_ready=0, err_orphan=0.
  - Round-robin pointer rr_ptr=0, lock=0, tag FIFO empty, inflight=0.
  - Reset mid-operation discards all tags. The engine shares rst, so in-flight vectors are dropped too; requesters must re-issue.
- Grant selection (combinational):
  - When lock=0, grant is the first r with req_valid[r]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - When lock=1, grant is the held index lock_idx.
- Issue (zero latency):
  - eng_in_valid = req_valid[grant] & (inflight<MAX_INFLIGHT).
  - eng_in_data = req_data slice[grant].
  - req_ready[grant] = eng_in_ready & (inflight<MAX_INFLIGHT); all other req_ready bits are 0.
- Input handshake:
  - Completes when eng_in_valid & eng_in_ready.
  - On completion: push grant into the tag FIFO, set rr_ptr=(grant+1) mod NUM_REQ, clear lock.
- Stability:
  - If eng_in_valid=1 and eng_in_ready=0, set lock=1 and lock_idx=grant.
  - The grant must not change until the handshake completes.
  - Requester data must be held stable (standard valid/ready rule).
- Response routing:
  - head = FIFO head tag.
  - rsp_valid[head] = eng_out_valid & !empty; all other bits are 0.
  - rsp_out1/rsp_out2 = eng_out1/eng_out2 passed straight through.
  - eng_out_ready = rsp_ready[head] & !empty.
  - Pop on eng_out_valid & eng_out_ready.
- inflight counter:
  - +1 on push only, −1 on pop only.
  - Unchanged on a simultaneous push and pop, including when full. Push is already gated by inflight<MAX_INFLIGHT from the previous cycle, so no overflow.
- Ordering: the engine is in-order, so results return in tag FIFO order. A back-pressuring requester stalls all results (head-of-line blocking).
- Orphan result: eng_out_valid=1 with an empty FIFO sets err_orphan=1 (sticky until rst). eng_out_ready stays 0.
- Requester idle: with no req_valid bits set, eng_in_valid=0 and rr_ptr is unchanged.

Optional Feature:
- Macro TILE_ARB_STATS_EN.
- Defined: adds output stat_cnt, NUM_REQ*16 bits. One 16-bit saturating counter per requester increments on each accepted input handshake from that requester. The counter holds at 16'hFFFF and clears on rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package tile_river_pkg:
  - DATA_W and VEC_LEN constants.
  - typedef vec_t (VEC_LEN×DATA_W packed).
  - typedef req_idx_t ($clog2(NUM_REQ) bits).
- One sub-module: tile_river_tag_fifo.
  - Synchronous, depth MAX_INFLIGHT, width req_idx_t.
  - push/pop, full/empty, count; async active-high rst.
- Arbiter logic and round-robin pointer stay in the top module.

Test Plan:
- Single requester:
  - Stimulus: req 0 issues 10 vectors back-to-back with rsp_ready=1 (engine per golden model files).
  - Response: 10 result pairs on rsp_valid[0] only, matching the expected outputs in order. rsp_valid[1] never asserts.
- Fairness:
  - Stimulus: both requesters hold req_valid=1 continuously.
  - Response: accepted grants alternate 0,1,0,1… Each requester receives its own results, with ordering verified by tag-annotated vectors.
- Inflight cap:
  - Stimulus: engine eng_out_ready path blocked (rsp_ready=0); requesters keep issuing.
  - Response: exactly 4 inputs accepted, then req_ready=0 and eng_in_valid=0. Raising rsp_ready for 1 cycle pops 1 result, and 1 new vector is accepted the following cycle.
- Lock under stall:
  - Stimulus: eng_in_ready=0 for 3 cycles while req 1 is granted and req 0 becomes valid.
  - Response: eng_in_data stays req 1's vector, and req 1 is accepted first.
- Orphan and reset:
  - Stimulus: force eng_out_valid=1 with the FIFO empty.
  - Response: err_orphan=1 next edge and eng_out_ready=0. Asserting rst mid-burst (2 tags outstanding) clears inflight, all outputs and err_orphan asynchronously.
- Stats (TILE_ARB_STATS_EN):
  - Stimulus: req 0 issues 3 vectors and req 1 issues 5.
  - Response: stat_cnt slice 0 = 3 and slice 1 = 5.
